// File: rtl/game_pkg.sv
// Shared game definitions: controller states and the per-level guess limits.
package game_pkg;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  // Largest legal entry for a level with the given digit count (9, 99, 999).
  function automatic logic [9:0] digit_limit(input logic [1:0] digits);
    case (digits)
      2'd1:    return 10'd9;
      2'd2:    return 10'd99;
      2'd3:    return 10'd999;
      default: return 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/round_tracker_if.sv
// Player/level inputs and scoreboard outputs of the round tracker.
interface round_tracker_if;
  logic       tick_1hz;
  logic       confirm_btn;
  logic [9:0] guess_value;
  logic [9:0] secret_value;
  logic [6:0] Max_timer;
  logic [2:0] Max_guess;
  logic [1:0] Max_digit;
  logic [6:0] timer;
  logic [2:0] guess;
  logic [2:0] round;
  logic       too_high;
  logic       too_low;
  logic       hit;
  logic       range_err;

  modport master (
    output tick_1hz, confirm_btn, guess_value, secret_value, Max_timer, Max_guess, Max_digit,
    input  timer, guess, round, too_high, too_low, hit, range_err
  );

  modport slave (
    input  tick_1hz, confirm_btn, guess_value, secret_value, Max_timer, Max_guess, Max_digit,
    output timer, guess, round, too_high, too_low, hit, range_err
  );
endinterface

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector; history restarts high so a held level is not an edge.
module rise_detect (
  input  logic clk,
  input  logic restart,
  input  logic d_i,
  output logic rise_o
);
  logic hist_q;

  always_ff @(posedge clk) begin
    if (restart) hist_q <= 1'b1;
    else         hist_q <= d_i;
  end

  assign rise_o = d_i & ~hist_q;
endmodule

// File: rtl/round_tracker.sv
// Guessing-game round controller: timer, guess and round counters plus result pulses.
module round_tracker
  import game_pkg::*;
(
  input  logic clk,
  input  logic restart,
  round_tracker_if.slave bus
);
  state_e     state_q, state_d;
  logic [6:0] timer_q, timer_d;
  logic [2:0] guess_q, guess_d;
  logic [2:0] round_q, round_d;
  logic [1:0] digit_q;
  logic [9:0] cap_q, cap_d;
  logic       too_high_q, too_high_d;
  logic       too_low_q, too_low_d;
  logic       hit_q, hit_d;
  logic       range_err_q, range_err_d;
  logic       confirm_rise;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  function automatic logic [6:0] sat_dec7(input logic [6:0] v, input logic en);
    return (en && v != 7'd0) ? v - 7'd1 : v;
  endfunction

  rise_detect u_confirm_rise (
    .clk    (clk),
    .restart(restart),
    .d_i    (bus.confirm_btn),
    .rise_o (confirm_rise)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    guess_d     = guess_q;
    round_d     = round_q;
    cap_d       = cap_q;
    too_high_d  = 1'b0;
    too_low_d   = 1'b0;
    hit_d       = 1'b0;
    range_err_d = 1'b0;

    // Level control overrides whatever the round was doing.
    if (bus.Max_digit == 2'd0) begin
      state_d = ST_HALT;
    end else if (bus.Max_digit != digit_q) begin
      round_d = 3'd0;
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          timer_d = bus.Max_timer;
          guess_d = 3'd0;
          state_d = ST_PLAY;
        end
        ST_PLAY: begin
          timer_d = sat_dec7(timer_q, bus.tick_1hz);
          if (confirm_rise) begin
            cap_d   = bus.guess_value;
            state_d = ST_CHECK;
          end else if (timer_q == 7'd0 || guess_q == bus.Max_guess) begin
            state_d = ST_LOCKED;
          end
        end
        ST_CHECK: begin
          timer_d = sat_dec7(timer_q, bus.tick_1hz);
          state_d = ST_PLAY;
          if (cap_q > digit_limit(bus.Max_digit)) begin
            range_err_d = 1'b1;
          end else begin
            guess_d = sat_inc3(guess_q);
            if (cap_q == bus.secret_value) begin
              hit_d   = 1'b1;
              round_d = sat_inc3(round_q);
              state_d = ST_LOAD;
            end else if (cap_q > bus.secret_value) begin
              too_high_d = 1'b1;
            end else begin
              too_low_d = 1'b1;
            end
          end
        end
        ST_LOCKED, ST_HALT: state_d = state_q;
        default:            state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state_q     <= ST_LOAD;
      timer_q     <= 7'd0;
      guess_q     <= 3'd0;
      round_q     <= 3'd0;
      too_high_q  <= 1'b0;
      too_low_q   <= 1'b0;
      hit_q       <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      guess_q     <= guess_d;
      round_q     <= round_d;
      too_high_q  <= too_high_d;
      too_low_q   <= too_low_d;
      hit_q       <= hit_d;
      range_err_q <= range_err_d;
    end
    digit_q <= bus.Max_digit;
  end

  // Captured entry is pure data; it is always rewritten before CHECK reads it.
  always_ff @(posedge clk) begin
    cap_q <= cap_d;
  end

  assign bus.timer     = timer_q;
  assign bus.guess     = guess_q;
  assign bus.round     = round_q;
  assign bus.too_high  = too_high_q;
  assign bus.too_low   = too_low_q;
  assign bus.hit       = hit_q;
  assign bus.range_err = range_err_q;
endmodule

// File: tb/tb_round_tracker.sv
// Scenario bench for round_tracker with a behavioural game model for random play.
module tb_round_tracker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  round_tracker_if bus();

  round_tracker dut (
    .clk    (clk),
    .restart(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural game model, stepped once per clock with the same inputs.
  localparam int M_LOAD = 0, M_PLAY = 1, M_CHECK = 2, M_LOCKED = 3, M_HALT = 4;
  int         m_mode;
  logic [6:0] m_timer;
  logic [2:0] m_guess, m_round;
  logic [9:0] m_cap;
  logic [1:0] m_level;
  logic       m_btn_prev;
  logic       m_th, m_tl, m_hit, m_re;

  task automatic model_step();
    bit pressed;
    int limit;
    int old_timer;
    if (rst) begin
      m_mode = M_LOAD; m_timer = 0; m_guess = 0; m_round = 0;
      {m_th, m_tl, m_hit, m_re} = 4'b0000;
      m_btn_prev = 1'b1;
      m_level = bus.Max_digit;
      return;
    end
    pressed = bus.confirm_btn && !m_btn_prev;
    m_btn_prev = bus.confirm_btn;
    {m_th, m_tl, m_hit, m_re} = 4'b0000;
    old_timer = m_timer;
    if (bus.Max_digit == 0) begin
      m_mode = M_HALT;
    end else if (bus.Max_digit != m_level) begin
      m_round = 0;
      m_mode = M_LOAD;
    end else if (m_mode == M_LOAD) begin
      m_timer = bus.Max_timer;
      m_guess = 0;
      m_mode = M_PLAY;
    end else if (m_mode == M_PLAY) begin
      if (bus.tick_1hz && old_timer > 0) m_timer = 7'(old_timer - 1);
      if (pressed) begin
        m_cap = bus.guess_value;
        m_mode = M_CHECK;
      end else if (old_timer == 0 || m_guess == bus.Max_guess) begin
        m_mode = M_LOCKED;
      end
    end else if (m_mode == M_CHECK) begin
      if (bus.tick_1hz && old_timer > 0) m_timer = 7'(old_timer - 1);
      limit = 10 ** int'(bus.Max_digit);
      m_mode = M_PLAY;
      if (int'(m_cap) >= limit) begin
        m_re = 1'b1;
      end else begin
        if (m_guess < 7) m_guess = m_guess + 1;
        if (m_cap == bus.secret_value) begin
          m_hit = 1'b1;
          if (m_round < 7) m_round = m_round + 1;
          m_mode = M_LOAD;
        end else if (m_cap > bus.secret_value) m_th = 1'b1;
        else m_tl = 1'b1;
      end
    end
    m_level = bus.Max_digit;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int v);
    bus.guess_value = 10'(v);
    bus.confirm_btn = 1'b1;
    cyc();
    bus.confirm_btn = 1'b0;
  endtask

  task automatic setup(input int d, input int t, input int g, input int s);
    bus.Max_digit = 2'(d); bus.Max_timer = 7'(t); bus.Max_guess = 3'(g);
    bus.secret_value = 10'(s); bus.tick_1hz = 1'b0; bus.confirm_btn = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  function automatic logic [3:0] pulses();
    return {bus.too_high, bus.too_low, bus.hit, bus.range_err};
  endfunction

  task automatic test_reset();
    setup(1, 30, 7, 7);
    n_total++;
    if ({bus.timer, bus.guess, bus.round, pulses()} !== 17'd0)
      $display("FAIL reset_state: got t=%0d g=%0d r=%0d p=%b, want all zero", bus.timer, bus.guess, bus.round, pulses());
    else n_pass++;
    cyc();
    n_total++;
    if (bus.timer !== 7'd30) $display("FAIL load_timer: got %0d want 30", bus.timer);
    else n_pass++;
  endtask

  task automatic test_guess_sequence();
    int vals[3] = '{9, 3, 7};
    logic [3:0] exp_p[3] = '{4'b1000, 4'b0100, 4'b0010};
    setup(1, 30, 7, 7);
    cyc();
    for (int i = 0; i < 3; i++) begin
      press(vals[i]);
      cyc();
      n_total++;
      if (pulses() !== exp_p[i] || bus.guess !== 3'(i + 1))
        $display("FAIL seq_guess%0d: got p=%b g=%0d want p=%b g=%0d", i, pulses(), bus.guess, exp_p[i], i + 1);
      else n_pass++;
    end
    n_total++;
    if (bus.round !== 3'd1) $display("FAIL seq_round: got %0d want 1", bus.round);
    else n_pass++;
    cyc();
    n_total++;
    if (bus.guess !== 3'd0 || bus.timer !== 7'd30 || pulses() !== 4'b0)
      $display("FAIL seq_reload: got g=%0d t=%0d p=%b want g=0 t=30 p=0000", bus.guess, bus.timer, pulses());
    else n_pass++;
  endtask

  task automatic test_timeout();
    setup(1, 3, 7, 5);
    bus.tick_1hz = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (bus.timer !== 7'(3 - i)) $display("FAIL timeout_count%0d: got %0d want %0d", i, bus.timer, 3 - i);
      else n_pass++;
      if (i < 3) cyc();
    end
    repeat (4) cyc();
    n_total++;
    if (bus.timer !== 7'd0) $display("FAIL timeout_floor: got %0d want 0", bus.timer);
    else n_pass++;
    bus.tick_1hz = 1'b0;
    press(5);
    cyc();
    n_total++;
    if (pulses() !== 4'b0 || bus.guess !== 3'd0)
      $display("FAIL timeout_locked: got p=%b g=%0d want p=0000 g=0", pulses(), bus.guess);
    else n_pass++;
  endtask

  task automatic test_range_and_lock();
    setup(1, 30, 1, 3);
    cyc();
    press(42);
    cyc();
    n_total++;
    if (pulses() !== 4'b0001 || bus.guess !== 3'd0)
      $display("FAIL range_err: got p=%b g=%0d want p=0001 g=0", pulses(), bus.guess);
    else n_pass++;
    press(5);
    cyc();
    n_total++;
    if (pulses() !== 4'b1000 || bus.guess !== 3'd1)
      $display("FAIL last_guess: got p=%b g=%0d want p=1000 g=1", pulses(), bus.guess);
    else n_pass++;
    cyc();
    press(3);
    cyc();
    n_total++;
    if (pulses() !== 4'b0 || bus.guess !== 3'd1 || bus.round !== 3'd0)
      $display("FAIL guess_lock: got p=%b g=%0d r=%0d want p=0000 g=1 r=0", pulses(), bus.guess, bus.round);
    else n_pass++;
  endtask

  task automatic test_tick_confirm();
    setup(1, 2, 7, 4);
    cyc();
    bus.tick_1hz = 1'b1;
    cyc();
    press(4);
    n_total++;
    if (bus.timer !== 7'd0) $display("FAIL tick_with_press: got timer %0d want 0", bus.timer);
    else n_pass++;
    bus.tick_1hz = 1'b0;
    cyc();
    n_total++;
    if (pulses() !== 4'b0010 || bus.round !== 3'd1)
      $display("FAIL tick_press_hit: got p=%b r=%0d want p=0010 r=1", pulses(), bus.round);
    else n_pass++;
    cyc();
    n_total++;
    if (bus.timer !== 7'd2) $display("FAIL hit_reload: got timer %0d want 2", bus.timer);
    else n_pass++;
  endtask

  task automatic test_level_change();
    setup(1, 30, 7, 6);
    cyc();
    repeat (4) begin press(6); cyc(); cyc(); end
    n_total++;
    if (bus.round !== 3'd4) $display("FAIL level_prewins: got round %0d want 4", bus.round);
    else n_pass++;
    bus.Max_timer = 7'd60;
    bus.Max_digit = 2'd2;
    cyc();
    n_total++;
    if (bus.round !== 3'd0) $display("FAIL level_round_clear: got %0d want 0", bus.round);
    else n_pass++;
    cyc();
    n_total++;
    if (bus.timer !== 7'd60) $display("FAIL level_timer: got %0d want 60", bus.timer);
    else n_pass++;
    press(50);
    cyc();
    bus.tick_1hz = 1'b1;
    cyc(); cyc();
    bus.tick_1hz = 1'b0;
    bus.Max_digit = 2'd0;
    cyc();
    bus.tick_1hz = 1'b1;
    repeat (3) begin press(6); cyc(); end
    n_total++;
    if (bus.timer !== 7'd58 || bus.guess !== 3'd1 || bus.round !== 3'd0 || pulses() !== 4'b0)
      $display("FAIL halt_frozen: got t=%0d g=%0d r=%0d p=%b want t=58 g=1 r=0 p=0000",
               bus.timer, bus.guess, bus.round, pulses());
    else n_pass++;
    bus.tick_1hz = 1'b0;
    bus.Max_digit = 2'd3;
    cyc(); cyc();
    n_total++;
    if (bus.timer !== 7'd60 || bus.guess !== 3'd0)
      $display("FAIL halt_exit: got t=%0d g=%0d want t=60 g=0", bus.timer, bus.guess);
    else n_pass++;
  endtask

  task automatic test_restart_in_check();
    setup(1, 30, 7, 2);
    cyc();
    press(2); cyc(); cyc();
    press(2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_total++;
    if (pulses() !== 4'b0 || bus.round !== 3'd0 || bus.guess !== 3'd0 || bus.timer !== 7'd0)
      $display("FAIL restart_check: got p=%b r=%0d g=%0d t=%0d want all zero",
               pulses(), bus.round, bus.guess, bus.timer);
    else n_pass++;
    cyc();
    n_total++;
    if (bus.timer !== 7'd30) $display("FAIL restart_load: got timer %0d want 30", bus.timer);
    else n_pass++;
  endtask

  task automatic test_round_saturation();
    setup(1, 30, 7, 1);
    cyc();
    repeat (9) begin press(1); cyc(); cyc(); end
    n_total++;
    if (bus.round !== 3'd7) $display("FAIL round_sat: got %0d want 7", bus.round);
    else n_pass++;
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 3000; i++) begin
      rst = (i == 0) || ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 299) == 0) bus.Max_digit = 2'($urandom_range(0, 3));
      if (i == 0) bus.Max_digit = 2'($urandom_range(1, 3));
      if (rst || $urandom_range(0, 99) == 0) begin
        d = (bus.Max_digit == 0) ? 3 : int'(bus.Max_digit);
        bus.Max_timer = 7'($urandom_range(3, 20));
        bus.Max_guess = 3'($urandom_range(1, 7));
        bus.secret_value = 10'($urandom_range(0, 10 ** d - 1));
      end
      bus.tick_1hz = ($urandom_range(0, 3) == 0);
      bus.confirm_btn = ($urandom_range(0, 2) == 0);
      bus.guess_value = ($urandom_range(0, 2) == 0) ? bus.secret_value : 10'($urandom_range(0, 1023));
      cyc();
      n_total++;
      if (bus.timer !== m_timer || bus.guess !== m_guess || bus.round !== m_round ||
          pulses() !== {m_th, m_tl, m_hit, m_re})
        $display("FAIL random_cycle%0d: got t=%0d g=%0d r=%0d p=%b want t=%0d g=%0d r=%0d p=%b",
                 i, bus.timer, bus.guess, bus.round, pulses(), m_timer, m_guess, m_round,
                 {m_th, m_tl, m_hit, m_re});
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.tick_1hz = 1'b0; bus.confirm_btn = 1'b0; bus.guess_value = '0;
    bus.secret_value = '0; bus.Max_timer = '0; bus.Max_guess = '0; bus.Max_digit = 2'd1;
    @(negedge clk);
    test_reset();
    test_guess_sequence();
    test_timeout();
    test_range_and_lock();
    test_tick_confirm();
    test_level_change();
    test_restart_in_check();
    test_round_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
